// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: drives the integer register file's single write port.
// The in-order pipeline writeback always has priority. Long-latency results
// (divider, uncached loads) are queued in a small FIFO and drained when the
// pipeline leaves the port idle. A 32-bit scoreboard tracks destinations
// reserved by in-flight long-latency ops so decode can stall on hazards.
module regfile_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  // pipeline writeback
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wd,
  // long-latency issue / reservation
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  // long-latency result
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_wd,
  output logic        lu_ready,
  // decode hazard query
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        busy1,
  output logic        busy2,
  // pipeline backpressure
  output logic        stall_req,
  // register file write port
  output logic [4:0]  ad3,
  output logic [31:0] wd3,
  output logic        we3,
  // sticky protocol error
  output logic        err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  // Scoreboard of reserved destinations (bit 0 never set)
  logic [31:0]      sb_q, sb_d;

  // Result FIFO storage and bookkeeping
  logic [4:0]       mem_rd_q [FIFO_DEPTH];
  logic [31:0]      mem_wd_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Starvation tracking
  logic [STV_W-1:0] starve_q, starve_d;
  logic             stall_q, stall_d;

  // Sticky error
  logic             err_q, err_d;

  // Registered write port
  logic [4:0]       ad3_q, ad3_d;
  logic [31:0]      wd3_q, wd3_d;
  logic             we3_q, we3_d;

  // Per-cycle decisions
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             pipe_win;
  logic             reserve;
  logic [4:0]       head_rd;
  logic [31:0]      head_wd;

  assign fifo_empty = (count_q == '0);
  assign head_rd    = mem_rd_q[rd_ptr_q];
  assign head_wd    = mem_wd_q[rd_ptr_q];

  // Ready signals come only from registered state, so a same-cycle pop
  // never makes a full FIFO look ready.
  assign iss_ready  = !rst && ((iss_rd == 5'd0) || !sb_q[iss_rd]);
  assign lu_ready   = !rst && (count_q < CNT_W'(FIFO_DEPTH));

  assign push       = lu_valid && lu_ready;
  assign pipe_win   = pipe_we && (pipe_rd != 5'd0);
  assign pop        = !pipe_win && !fifo_empty;
  assign reserve    = iss_valid && iss_ready && (iss_rd != 5'd0);

  assign busy1      = sb_q[rs1];
  assign busy2      = sb_q[rs2];
  assign stall_req  = stall_q;
  assign ad3        = ad3_q;
  assign wd3        = wd3_q;
  assign we3        = we3_q;
  assign err        = err_q;

  // Next-state for scoreboard, FIFO bookkeeping, arbitration and starvation
  always_comb begin
    sb_d     = sb_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    err_d    = err_q;
    ad3_d    = ad3_q;
    wd3_d    = wd3_q;
    we3_d    = 1'b0;

    // A popped register cannot be reserved in the same cycle (its bit is
    // still set, so iss_ready is low); clear and set never target one bit.
    if (pop) begin
      sb_d[head_rd] = 1'b0;
    end
    if (reserve) begin
      sb_d[iss_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (!sb_q[lu_rd]) begin
        err_d = 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (pipe_win) begin
      ad3_d = pipe_rd;
      wd3_d = pipe_wd;
      we3_d = 1'b1;
    end else if (pop) begin
      ad3_d = head_rd;
      wd3_d = head_wd;
      we3_d = (head_rd != 5'd0);
    end

    // Non-empty and not popped means the pipeline took the port.
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q != STV_W'(STARVE_MAX)) begin
      starve_d = starve_q + STV_W'(1);
    end

    stall_d = (starve_q == STV_W'(STARVE_MAX));
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
      ad3_q    <= '0;
      wd3_q    <= '0;
      we3_q    <= 1'b0;
    end else begin
      sb_q     <= sb_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
      ad3_q    <= ad3_d;
      wd3_q    <= wd3_d;
      we3_q    <= we3_d;
    end
  end

  // FIFO payload storage; contents are don't-care once pointers reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[wr_ptr_q] <= lu_rd;
      mem_wd_q[wr_ptr_q] <= lu_wd;
    end
  end

endmodule
